// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) engine driving the Hi/Lo pair.
// Optional MULDIV_ZERO_BYPASS_EN: zero operands skip the iterations and write 0 straight away.
module muldiv_sequencer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_mult,
    input  logic              start_div,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [DATA_W-1:0] mult_hi,
    output logic [DATA_W-1:0] mult_lo,
    output logic [DATA_W-1:0] div_hi,
    output logic [DATA_W-1:0] div_lo,
    output logic              hi_sel,
    output logic              lo_sel,
    output logic              hi_write,
    output logic              lo_write
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_WRITE, S_DZERO} state_t;

    state_t              r_state, w_state_next;
    logic [DATA_W:0]     r_acc;
    logic [DATA_W-1:0]   r_q, r_m;
    logic                r_qm1, r_neg_q, r_neg_r, r_sel;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_mult_hi, r_mult_lo, r_div_hi, r_div_lo;

    logic                w_mult_bypass, w_div_bypass;
    logic [DATA_W-1:0]   w_abs_a, w_abs_b;
    logic [DATA_W:0]     w_m_ext, w_booth_sum, w_booth_acc;
    logic [DATA_W-1:0]   w_booth_q;
    logic [DATA_W:0]     w_div_sh, w_trial, w_div_acc;
    logic [DATA_W-1:0]   w_div_q, w_quot, w_rem;

`ifdef MULDIV_ZERO_BYPASS_EN
    assign w_mult_bypass = (op_a == '0) || (op_b == '0);
    assign w_div_bypass  = (op_a == '0);
`else
    assign w_mult_bypass = 1'b0;
    assign w_div_bypass  = 1'b0;
`endif

    assign w_abs_a = op_a[DATA_W-1] ? -op_a : op_a;
    assign w_abs_b = op_b[DATA_W-1] ? -op_b : op_b;

    // Booth step: acc is one bit wider so acc +/- multiplicand never overflows.
    assign w_m_ext = {r_m[DATA_W-1], r_m};
    always_comb begin
        w_booth_sum = r_acc;
        case ({r_q[0], r_qm1})
            2'b01:   w_booth_sum = r_acc + w_m_ext;
            2'b10:   w_booth_sum = r_acc - w_m_ext;
            default: w_booth_sum = r_acc;
        endcase
    end
    assign w_booth_acc = {w_booth_sum[DATA_W], w_booth_sum[DATA_W:1]};
    assign w_booth_q   = {w_booth_sum[0], r_q[DATA_W-1:1]};

    // Restoring step on magnitudes; the trial sign bit decides restore vs. keep.
    assign w_div_sh  = {r_acc[DATA_W-1:0], r_q[DATA_W-1]};
    assign w_trial   = w_div_sh - {1'b0, r_m};
    assign w_div_acc = w_trial[DATA_W] ? w_div_sh : w_trial;
    assign w_div_q   = {r_q[DATA_W-2:0], ~w_trial[DATA_W]};
    assign w_quot    = r_neg_q ? -w_div_q : w_div_q;
    assign w_rem     = r_neg_r ? -w_div_acc[DATA_W-1:0] : w_div_acc[DATA_W-1:0];

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        done         = 1'b0;
        div_zero     = 1'b0;
        hi_write     = 1'b0;
        lo_write     = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start_mult)
                    w_state_next = w_mult_bypass ? S_WRITE : S_MULT;
                else if (start_div) begin
                    if (op_b == '0)        w_state_next = S_DZERO;
                    else if (w_div_bypass) w_state_next = S_WRITE;
                    else                   w_state_next = S_DIV;
                end
            end
            S_MULT:  if (r_cnt == CNT_LAST) w_state_next = S_WRITE;
            S_DIV:   if (r_cnt == CNT_LAST) w_state_next = S_WRITE;
            S_WRITE: begin
                done         = 1'b1;
                hi_write     = 1'b1;
                lo_write     = 1'b1;
                w_state_next = S_IDLE;
            end
            S_DZERO: begin
                done         = 1'b1;
                div_zero     = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc     <= '0;
            r_q       <= '0;
            r_m       <= '0;
            r_qm1     <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_sel     <= 1'b0;
            r_cnt     <= '0;
            r_mult_hi <= '0;
            r_mult_lo <= '0;
            r_div_hi  <= '0;
            r_div_lo  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_acc <= '0;
                    r_qm1 <= 1'b0;
                    r_cnt <= CNT_INIT;
                    if (start_mult) begin
                        r_sel <= 1'b1;
                        r_m   <= op_a;
                        r_q   <= op_b;
                        if (w_mult_bypass) begin
                            r_mult_hi <= '0;
                            r_mult_lo <= '0;
                        end
                    end else if (start_div) begin
                        r_sel   <= 1'b0;
                        r_m     <= w_abs_b;
                        r_q     <= w_abs_a;
                        r_neg_q <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
                        r_neg_r <= op_a[DATA_W-1];
                        if (w_div_bypass && (op_b != '0)) begin
                            r_div_hi <= '0;
                            r_div_lo <= '0;
                        end
                    end
                end
                S_MULT: begin
                    r_acc <= w_booth_acc;
                    r_q   <= w_booth_q;
                    r_qm1 <= r_q[0];
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_mult_hi <= w_booth_acc[DATA_W-1:0];
                        r_mult_lo <= w_booth_q;
                    end
                end
                S_DIV: begin
                    r_acc <= w_div_acc;
                    r_q   <= w_div_q;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_div_hi <= w_rem;
                        r_div_lo <= w_quot;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mult_hi = r_mult_hi;
    assign mult_lo = r_mult_lo;
    assign div_hi  = r_div_hi;
    assign div_lo  = r_div_lo;
    assign hi_sel  = r_sel;
    assign lo_sel  = r_sel;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus randomized ops
// checked against an arithmetic reference model.
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_mult = 1'b0, start_div = 1'b0;
    logic [31:0] op_a = '0, op_b = '0;
    logic        busy, done, div_zero, hi_sel, lo_sel, hi_write, lo_write;
    logic [31:0] mult_hi, mult_lo, div_hi, div_lo;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_mh = '0, exp_ml = '0, exp_dh = '0, exp_dl = '0;

    muldiv_sequencer #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .div_zero(div_zero),
        .mult_hi(mult_hi), .mult_lo(mult_lo), .div_hi(div_hi), .div_lo(div_lo),
        .hi_sel(hi_sel), .lo_sel(lo_sel), .hi_write(hi_write), .lo_write(lo_write)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: plain signed arithmetic with the divider's wrap case spelled out.
    task automatic model(input logic is_mult, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int sa, sb;
        if (is_mult) begin
            p = longint'($signed(a)) * longint'($signed(b));
            exp_mh = p[63:32];
            exp_ml = p[31:0];
        end else if (b != 0) begin
            sa = a;
            sb = b;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                exp_dl = 32'h8000_0000;
                exp_dh = 32'h0;
            end else begin
                exp_dl = sa / sb;
                exp_dh = sa % sb;
            end
        end
    endtask

    function automatic int exp_latency(input logic is_mult, input logic [31:0] a, input logic [31:0] b);
        if (!is_mult && b == 0) return 0;
`ifdef MULDIV_ZERO_BYPASS_EN
        if (is_mult && (a == 0 || b == 0)) return 0;
        if (!is_mult && a == 0) return 0;
`endif
        return 32;
    endfunction

    // Issue strobes for one cycle; returns just after edge E0.
    task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        start_mult = m; start_div = d; op_a = a; op_b = b;
        @(posedge clk); #1;
        start_mult = 1'b0; start_div = 1'b0;
    endtask

    // Runs one full transaction; poke >= 0 pulses start_div during that cycle after E0.
    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b, input int poke);
        int lat, want;
        logic is_mult, dz;
        is_mult = m;
        dz = !m && (b == 0);
        want = exp_latency(is_mult, a, b);
        issue(m, d, a, b);
        model(is_mult, a, b);
        check({tag, ".busy"}, {31'b0, busy}, 32'd1);
        lat = 0;
        while (!done && lat < 40) begin
            if (lat == poke) begin
                start_div = 1'b1; op_a = 32'd99; op_b = 32'd3;
            end
            @(posedge clk); #1;
            start_div = 1'b0;
            lat++;
        end
        check({tag, ".latency"}, lat, want);
        check({tag, ".div_zero"}, {31'b0, div_zero}, {31'b0, dz});
        check({tag, ".hi_write"}, {31'b0, hi_write}, {31'b0, !dz});
        check({tag, ".lo_write"}, {31'b0, lo_write}, {31'b0, !dz});
        if (!dz) begin
            check({tag, ".hi_sel"}, {31'b0, hi_sel}, {31'b0, is_mult});
            check({tag, ".lo_sel"}, {31'b0, lo_sel}, {31'b0, is_mult});
        end
        check({tag, ".mult_hi"}, mult_hi, exp_mh);
        check({tag, ".mult_lo"}, mult_lo, exp_ml);
        check({tag, ".div_hi"}, div_hi, exp_dh);
        check({tag, ".div_lo"}, div_lo, exp_dl);
        $display("[TB] %s m=%0b d=%0b a=%h b=%h lat=%0d mult=%h_%h div q=%h r=%h dz=%0b",
                 tag, m, d, a, b, lat, mult_hi, mult_lo, div_lo, div_hi, div_zero);
        @(posedge clk); #1;
        check({tag, ".done_once"}, {31'b0, done}, 32'd0);
        check({tag, ".idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rm;
        #2;
        check("reset.busy", {31'b0, busy}, 32'd0);
        check("reset.done", {31'b0, done}, 32'd0);
        check("reset.hi_write", {31'b0, hi_write}, 32'd0);
        check("reset.mult_lo", mult_lo, 32'd0);
        check("reset.div_lo", div_lo, 32'd0);
        @(posedge clk); #1 reset = 1'b1;

        run_op("mul_7x-3",   1, 0, 32'd7,          32'hFFFF_FFFD, -1);
        check("mul_7x-3.hi_const", mult_hi, 32'hFFFF_FFFF);
        check("mul_7x-3.lo_const", mult_lo, 32'hFFFF_FFEB);
        run_op("div_-7/2",   0, 1, 32'hFFFF_FFF9,  32'd2,        -1);
        check("div_-7/2.q_const", div_lo, 32'hFFFF_FFFD);
        check("div_-7/2.r_const", div_hi, 32'hFFFF_FFFF);
        run_op("div_5/0",    0, 1, 32'd5,          32'd0,        -1);
        run_op("div_wrap",   0, 1, 32'h8000_0000,  32'hFFFF_FFFF, -1);
        check("div_wrap.q_const", div_lo, 32'h8000_0000);
        run_op("mul_min2",   1, 0, 32'h8000_0000,  32'h8000_0000, -1);
        check("mul_min2.hi_const", mult_hi, 32'h4000_0000);
        run_op("busy_ignore", 1, 0, 32'd12345,     32'hFFFF_0001, 10);
        run_op("both_strobe", 1, 1, 32'd1000,      32'd3,        -1);
        run_op("mul_zero",   1, 0, 32'd0,          32'd9,        -1);

        issue(0, 1, 32'd100, 32'd7);
        repeat (14) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("abort.busy", {31'b0, busy}, 32'd0);
        check("abort.done", {31'b0, done}, 32'd0);
        check("abort.hi_write", {31'b0, hi_write}, 32'd0);
        check("abort.div_lo", div_lo, 32'd0);
        check("abort.mult_lo", mult_lo, 32'd0);
        $display("[TB] abort: reset asserted mid-divide busy=%0b done=%0b", busy, done);
        exp_mh = '0; exp_ml = '0; exp_dh = '0; exp_dl = '0;
        @(posedge clk); #1 reset = 1'b1;
        run_op("div_6/4",    0, 1, 32'd6,          32'd4,        -1);
        check("div_6/4.q_const", div_lo, 32'd1);
        check("div_6/4.r_const", div_hi, 32'd2);

        for (int i = 0; i < 16; i++) begin
            rm = $urandom_range(0, 1);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: ra = 32'd0;
                2: rb = $urandom_range(1, 9);
                3: ra = -$urandom_range(1, 1000);
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), rm, !rm, ra, rb, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
